// File: rtl/axi_lite_aw_accept_fifo_if.sv
// Bundle of the AXI-lite write-address channel and the downstream
// head-of-FIFO port of axi_lite_aw_accept_fifo.
//
// Handshake rule for both pairs (AWVALID/AWREADY and valid_o/ready_i):
// a transfer happens on a rising clk edge where valid and ready are both 1.
// Ready never depends combinationally on valid. Once valid is raised with
// its payload, the payload holds until that transfer occurs.
interface axi_lite_aw_accept_fifo_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Write-address channel from the master
  logic [31:0]   AWADDR;
  logic          AWVALID;
  logic          AWREADY;

  // Head-of-FIFO presentation to the downstream stage
  logic [31:0]   addr_o;
  logic [1:0]    err_o;
  logic          valid_o;
  logic          ready_i;
  logic [CW-1:0] count_o;

  // The FIFO side of the bundle
  modport slave (
    input  AWADDR, AWVALID, ready_i,
    output AWREADY, addr_o, err_o, valid_o, count_o
  );

  // The master / downstream-consumer side of the bundle
  modport master (
    output AWADDR, AWVALID, ready_i,
    input  AWREADY, addr_o, err_o, valid_o, count_o
  );
endinterface

// File: rtl/axi_lite_aw_accept_fifo.sv
// Slave-side write-address acceptor. It classifies each accepted AWADDR for
// alignment and for window membership. It queues the address and its status
// in a DEPTH-entry FIFO and presents the head entry to the downstream stage.
// Erroneous addresses are still queued so the downstream stage can answer
// them with SLVERR.
module axi_lite_aw_accept_fifo #(
  parameter int unsigned DEPTH       = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] RANGE_BYTES = 32'h0000_1000
) (
  input logic                     clk,
  input logic                     reset,
  axi_lite_aw_accept_fifo_if.slave bus
);

  localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [31:0]   WIN_MASK = ~(RANGE_BYTES - 32'd1);

  logic          reset_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_mem_q [DEPTH];
  logic [1:0]    err_mem_q  [DEPTH];

  logic          full;
  logic          empty;
  logic          aw_ready;
  logic          push;
  logic          pop;
  logic [1:0]    push_err;

  // reset_q keeps AWREADY low for every cycle in which reset was sampled
  // high. Ready then rises exactly one cycle after reset is released.
  always_ff @(posedge clk) begin
    reset_q <= reset;
  end

  // Handshake qualifiers. AWREADY uses registered state only, so it does not
  // see a same-cycle pop. A full FIFO therefore refuses AWVALID for that
  // whole cycle.
  always_comb begin
    full     = (count_q == DEPTH_C);
    empty    = (count_q == '0);
    aw_ready = !reset_q && !full;
    push     = bus.AWVALID && aw_ready;
    pop      = !empty && bus.ready_i;
  end

  // Classify the address being offered. The result is stored only on a push.
  always_comb begin
    push_err    = 2'b00;
    push_err[0] = (bus.AWADDR[1:0] != 2'b00);
    push_err[1] = ((bus.AWADDR & WIN_MASK) != BASE_ADDR);
  end

  // Next-state for pointers and occupancy. Both pointers wrap naturally
  // because DEPTH is a power of two. Push plus pop leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers. Reset discards all stored and in-flight
  // entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage. AWADDR is captured only on the handshake edge. Old
  // contents are left in place across reset. They can never become visible,
  // because the outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      addr_mem_q[wr_ptr_q] <= bus.AWADDR;
      err_mem_q[wr_ptr_q]  <= push_err;
    end
  end

  // Outputs come from registered state only. Head data reads as zero while
  // the FIFO is empty, so stale entries never show after a reset.
  assign bus.AWREADY = aw_ready;
  assign bus.valid_o = !empty;
  assign bus.count_o = count_q;
  assign bus.addr_o  = empty ? 32'h0 : addr_mem_q[rd_ptr_q];
  assign bus.err_o   = empty ? 2'b00 : err_mem_q[rd_ptr_q];

  // Occupancy must never exceed the FIFO depth.
  a_count_range : assert property (@(posedge clk) disable iff (reset)
    count_q <= DEPTH_C);

endmodule

// File: tb/tb_axi_lite_aw_accept_fifo.sv
// Self-checking bench for axi_lite_aw_accept_fifo (DEPTH=4, window 0x0..0xFFF).
// A reference model tracks occupancy and the registered reset. A scoreboard
// queue holds {err, addr} for every accepted address and is compared at
// each pop.
module tb_axi_lite_aw_accept_fifo;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  axi_lite_aw_accept_fifo_if #(.DEPTH(DEPTH)) bus ();

  axi_lite_aw_accept_fifo #(
    .DEPTH      (DEPTH),
    .BASE_ADDR  (32'h0000_0000),
    .RANGE_BYTES(32'h0000_1000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [33:0] exp_q[$];
  int          m_count   = 0;
  logic        m_reset_q = 1'b1;

  typedef struct {
    logic        awvalid;
    logic [31:0] awaddr;
    logic        ready;
    logic        exp_awready;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [1:0]  exp_err;
    int          exp_count;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent classification: misaligned if not a multiple of 4.
  // Out of window if outside [0x0, 0x1000).
  function automatic logic [1:0] classify(input logic [31:0] a);
    logic mis;
    logic oow;
    mis = ((a % 32'd4) != 32'd0);
    oow = !(a < 32'h0000_1000);
    return {oow, mis};
  endfunction

  // ---------------- driver: one clock cycle ----------------
  // Entered at posedge+1. Drives the inputs and checks the outputs against
  // the model. Then clocks one edge, updates the model, and returns at
  // posedge+1.
  task automatic cycle(input logic rst, input logic awv, input logic [31:0] awa,
                       input logic rdy);
    logic        exp_ready;
    logic        push;
    logic        pop;
    logic [33:0] head;
    reset       = rst;
    bus.AWVALID = awv;
    bus.AWADDR  = awa;
    bus.ready_i = rdy;
    #1;
    exp_ready = !m_reset_q && (m_count < DEPTH);
    chk("awready", 32'(bus.AWREADY), 32'(exp_ready));
    chk("valid",   32'(bus.valid_o), 32'(m_count != 0));
    chk("count",   32'(bus.count_o), 32'(m_count));
    if (m_reset_q) begin
      chk("rst_addr", bus.addr_o, 32'h0);
      chk("rst_err",  32'(bus.err_o), 32'h0);
    end
    push = awv && exp_ready;
    pop  = (m_count != 0) && rdy;
    if (m_count != 0 && exp_q.size() != 0) begin
      head = exp_q[0];
      chk("head_addr", bus.addr_o, head[31:0]);
      chk("head_err",  32'(bus.err_o), 32'(head[33:32]));
      if (pop) void'(exp_q.pop_front());
    end
    @(posedge clk);
    m_reset_q = rst;
    if (rst) begin
      exp_q.delete();
      m_count = 0;
    end else begin
      if (push) exp_q.push_back({classify(awa), awa});
      m_count = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
    end
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    // Single-write, error-class and window-boundary vectors. Each row starts
    // from the state the previous row leaves behind, with the FIFO empty
    // before row 0.
    //         awv   awaddr        rdy   awrdy valid exp_addr      err    cnt
    vecs[0]  = '{1'b1, 32'h0000_0010, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 2'b00, 0};
    vecs[1]  = '{1'b1, 32'h0000_0013, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 2'b00, 1};
    vecs[2]  = '{1'b1, 32'h0000_2000, 1'b1, 1'b1, 1'b1, 32'h0000_0013, 2'b01, 1};
    vecs[3]  = '{1'b1, 32'h0000_2001, 1'b1, 1'b1, 1'b1, 32'h0000_2000, 2'b10, 1};
    vecs[4]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_2001, 2'b11, 1};
    vecs[5]  = '{1'b1, 32'h0000_0FFC, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'b00, 0};
    vecs[6]  = '{1'b1, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 32'h0000_0FFC, 2'b00, 1};
    vecs[7]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0FFC, 2'b00, 2};
    vecs[8]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0FFC, 2'b00, 2};
    vecs[9]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 2'b10, 1};
    vecs[10] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 2'b00, 0};

    reset       = 1'b1;
    bus.AWVALID = 1'b0;
    bus.AWADDR  = 32'h0;
    bus.ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held with AWVALID high: nothing is accepted. After release,
    // AWREADY rises and the held address is taken.
    repeat (3) cycle(1'b1, 1'b1, 32'h0000_0100, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0100, 1'b0);
    chk("release_awready", 32'(bus.AWREADY), 32'h1);
    cycle(1'b0, 1'b1, 32'h0000_0100, 1'b0);
    chk("release_valid", 32'(bus.valid_o), 32'h1);
    chk("release_addr", bus.addr_o, 32'h0000_0100);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Table-driven single write, error classes and window edges
    for (int i = 0; i < 11; i++) begin
      reset       = 1'b0;
      bus.AWVALID = vecs[i].awvalid;
      bus.AWADDR  = vecs[i].awaddr;
      bus.ready_i = vecs[i].ready;
      #1;
      chk($sformatf("vec%0d_awready", i), 32'(bus.AWREADY), 32'(vecs[i].exp_awready));
      chk($sformatf("vec%0d_valid", i), 32'(bus.valid_o), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_count", i), 32'(bus.count_o), 32'(vecs[i].exp_count));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_addr", i), bus.addr_o, vecs[i].exp_addr);
        chk($sformatf("vec%0d_err", i), 32'(bus.err_o), 32'(vecs[i].exp_err));
      end
      cycle(1'b0, vecs[i].awvalid, vecs[i].awaddr, vecs[i].ready);
    end

    // Fill to full with ready_i low. The 5th address stalls until the cycle
    // after the first pop.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'h0000_0020 + 32'(i * 4), 1'b0);
    chk("full_count", 32'(bus.count_o), 32'd4);
    chk("full_awready", 32'(bus.AWREADY), 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0030, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0030, 1'b1);
    chk("after_pop_awready", 32'(bus.AWREADY), 32'h1);
    chk("after_pop_count", 32'(bus.count_o), 32'd3);
    cycle(1'b0, 1'b1, 32'h0000_0030, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("drain_count", 32'(bus.count_o), 32'd0);

    // Steady stream at half fill. 20 push+pop cycles exercise pointer wrap.
    cycle(1'b0, 1'b1, 32'h0000_0200, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0204, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 32'h0000_0208 + 32'(i * 4), 1'b1);
      chk("stream_count", 32'(bus.count_o), 32'd2);
    end
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset with three entries stored. The old entries must never reappear.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h0000_0A00 + 32'(i * 4), 1'b0);
    chk("pre_reset_count", 32'(bus.count_o), 32'd3);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    chk("post_reset_valid", 32'(bus.valid_o), 32'h0);
    chk("post_reset_count", 32'(bus.count_o), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0B00, 1'b1);
    chk("fresh_addr", bus.addr_o, 32'h0000_0B00);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      logic        r_rst;
      logic        r_awv;
      logic        r_rdy;
      logic [31:0] r_addr;
      r_rst  = ($urandom_range(0, 59) == 0);
      r_awv  = ($urandom_range(0, 3) != 0);
      r_rdy  = ($urandom_range(0, 2) != 0);
      r_addr = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 32'h0000_0FFF))
                                           : $urandom();
      cycle(r_rst, r_awv, r_addr, r_rdy);
    end
    repeat (DEPTH + 2) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("final_count", 32'(bus.count_o), 32'd0);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
